// File: rtl/load_store_unit_pkg.sv
// Shared RV32I core definitions: load/store width codes, LSU state encoding
// and the request legality rule used at acceptance time.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_MEM  = 2'd1;
    localparam logic [1:0] LSU_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = LSU_IDLE,
        ST_MEM  = LSU_MEM,
        ST_RESP = LSU_RESP
    } lsu_state_t;

    // Unknown width codes, unsigned stores and misaligned h/w accesses are rejected.
    function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = we;
            F3_H:    bad = offset[0];
            F3_HU:   bad = we | offset[0];
            F3_W:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave: the LSU itself; master: the pipeline and memory around it.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        flush;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rdata, flush,
        output req_ready, mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output rsp_valid, rsp_data, rsp_rd, rsp_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rdata, flush,
        input  req_ready, mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  rsp_valid, rsp_data, rsp_rd, rsp_err
    );

endinterface

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, store replication and load
// extract/extend for one access described by funct3 and the address offset.
module load_store_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Lane selection by access size, then load extension by width code.
    always_comb begin
        be        = '0;
        wdata     = '0;
        load_data = '0;
        shifted   = read_data >> {offset, 3'b000};
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            F3_W:    load_data = read_data;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request, runs a single-beat memory
// transaction with timeout, and returns a one-cycle response to writeback.
module load_store_unit
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t    state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [4:0]    rd_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;
    logic          flushed;
    logic          accept;
    logic          in_mem;
    logic          in_resp;
    logic [3:0]    be;
    logic [31:0]   store_lanes;
    logic [31:0]   load_data;

    load_store_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .store_data (wdata_q),
        .read_data  (bus.mem_rdata),
        .be         (be),
        .wdata      (store_lanes),
        .load_data  (load_data)
    );

    assign in_mem     = (state == ST_MEM);
    assign in_resp    = (state == ST_RESP);
    assign accept     = (state == ST_IDLE) && bus.req_valid && !bus.flush;
    assign count_next = count + CW'(1);

    assign bus.req_ready = (state == ST_IDLE) && !bus.flush;
    assign bus.mem_valid = in_mem;
    assign bus.mem_we    = in_mem & we_q;
    assign bus.mem_be    = in_mem ? be : '0;
    assign bus.mem_addr  = in_mem ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_wdata = in_mem ? store_lanes : '0;
    assign bus.rsp_valid = in_resp && !flushed && !bus.flush;
    assign bus.rsp_data  = in_resp ? rsp_data_q : '0;
    assign bus.rsp_rd    = in_resp ? rd_q : '0;
    assign bus.rsp_err   = in_resp & rsp_err_q;

    // FSM, request capture, timeout counting and response latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            flushed    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q       <= bus.req_we;
                        funct3_q   <= bus.req_funct3;
                        addr_q     <= bus.req_addr;
                        wdata_q    <= bus.req_wdata;
                        rd_q       <= bus.req_rd;
                        rsp_data_q <= '0;
                        flushed    <= 1'b0;
                        count      <= '0;
                        if (lsu_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                            rsp_err_q <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            rsp_err_q <= 1'b0;
                            state     <= ST_MEM;
                        end
                    end
                end
                ST_MEM: begin
                    if (bus.flush) begin
                        flushed <= 1'b1;
                    end
                    // Completion is checked first so it wins over a same-cycle timeout.
                    if (bus.mem_ready) begin
                        rsp_data_q <= we_q ? '0 : load_data;
                        state      <= ST_RESP;
                    end else begin
                        count <= count_next;
                        if ((TIMEOUT != 0) && (count_next == CW'(TIMEOUT))) begin
                            rsp_err_q <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan items followed by
// randomized requests checked against an arithmetic reference model.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (addr % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned mask;
        mask = (1 << m_size(f3)) - 1;
        return 4'((mask << (addr % 4)) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return 32'(wd[7:0]) * 32'h0101_0101;
            2:       return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned sz;
        logic [31:0] lane, mask, val;
        sz   = m_size(f3);
        lane = rdata >> (8 * (addr % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        val  = lane & mask;
        if (!f3[2] && sz < 4 && lane[8 * sz - 1]) val = val | ~mask;
        return val;
    endfunction

    // fmode: 0 none, 1 flush in first MEM cycle, 2 flush in RESP cycle.
    // delay: MEM cycles with mem_ready low before it rises (>= TMO times out).
    // Entered and left at #1 after a rising edge.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int unsigned delay, input logic [31:0] rdata,
                           input int unsigned fmode);
        logic        ill, timed_out, exp_valid;
        logic [31:0] exp_data;
        int unsigned n_mem;
        ill       = m_illegal(we, f3, addr);
        timed_out = !ill && (delay >= TMO);
        exp_valid = !(fmode == 2 || (fmode == 1 && !ill));
        exp_data  = (ill || timed_out || we) ? 32'h0 : m_load(f3, addr, rdata);

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        @(negedge clk);
        chk("req_ready_at_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_rd     = 5'($urandom);

        if (!ill) begin
            n_mem = (delay < TMO) ? delay + 1 : TMO;
            for (int unsigned k = 0; k < n_mem; k++) begin
                bus.mem_ready = (k == delay);
                bus.mem_rdata = (k == delay) ? rdata : $urandom;
                bus.flush     = (fmode == 1 && k == 0);
                @(negedge clk);
                chk("mem_valid", 32'(bus.mem_valid), 32'd1);
                chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
                chk("mem_be", 32'(bus.mem_be), 32'(m_be(f3, addr)));
                chk("mem_we", 32'(bus.mem_we), 32'(we));
                if (we) chk("mem_wdata", bus.mem_wdata, m_wdata(f3, wdata));
                chk("rsp_valid_in_mem", 32'(bus.rsp_valid), 32'd0);
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
                bus.flush     = 1'b0;
            end
        end

        bus.flush     = (fmode == 2);
        bus.mem_ready = 1'($urandom);
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        chk("mem_valid_in_resp", 32'(bus.mem_valid), 32'd0);
        if (exp_valid) begin
            chk("rsp_err", 32'(bus.rsp_err), 32'(ill || timed_out));
            chk("rsp_data", bus.rsp_data, exp_data);
            chk("rsp_rd", 32'(bus.rsp_rd), 32'(rd));
        end
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rsp_valid_one_cycle", 32'(bus.rsp_valid), 32'd0);
        chk("mem_valid_idle", 32'(bus.mem_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int unsigned r_sel;
        int unsigned r_mode;

        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("reset_mem_be", 32'(bus.mem_be), 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk);
        #1;

        // Directed plan items
        run_txn(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 0, 32'h0, 0);
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd2, 0, 32'h80FF_1234, 0);
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd3, 1, 32'h80FF_1234, 0);
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h8001_0000, 0);
        run_txn(1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd5, 0, 32'h0, 0);
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd6, 10, 32'h1234_5678, 0);
        run_txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd7, 0, 32'h0, 0);
        run_txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd8, 2, 32'h0, 1);
        run_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd9, TMO - 1, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 3'b101, 32'h0000_0302, 32'h0, 5'd10, 1, 32'hFEDC_BA98, 2);
        run_txn(1'b1, 3'b100, 32'h0000_0300, 32'h0, 5'd11, 0, 32'h0, 0);
        run_txn(1'b0, 3'b011, 32'h0000_0300, 32'h0, 5'd12, 0, 32'h0, 0);

        // Flush while idle blocks acceptance
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0400;
        bus.flush      = 1'b1;
        @(negedge clk);
        chk("flush_idle_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_mem", 32'(bus.mem_valid), 32'd0);
        chk("flush_idle_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the second MEM cycle abandons the transaction
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0500;
        bus.req_rd     = 5'd13;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mem_cycle1", 32'(bus.mem_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mem_cycle2", 32'(bus.mem_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_valid_drop", 32'(bus.mem_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        run_txn(1'b0, 3'b010, 32'h0000_0504, 32'h0, 5'd14, 0, 32'h0BAD_F00D, 0);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            r_we   = 1'($urandom);
            r_f3   = 3'($urandom);
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                r_addr = r_addr - (r_addr % m_size(r_f3));
            end
            r_sel  = $urandom_range(0, 9);
            r_mode = (r_sel == 0) ? 1 : ((r_sel == 1) ? 2 : 0);
            run_txn(r_we, r_f3, r_addr, $urandom, 5'($urandom),
                    $urandom_range(0, TMO + 2), $urandom, r_mode);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
